// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its memory/trap environment.
//
// Handshake rules: a request (o_fetchReq, o_memReq) is held high for as long as
// the sequencer sits in the requesting state; the environment completes the
// transfer by raising the matching ack (i_fetchAck, i_memAck) for one cycle
// while the request is high, and the transfer is taken on that rising edge.
// An ack seen while its request is low is ignored, as is i_trapClear outside
// TRAP. i_instr only needs to be valid in the cycle i_fetchAck is high.
interface instr_sequencer_if;
    logic [31:0] i_instr;
    logic        o_fetchReq;
    logic        i_fetchAck;
    logic        o_memReq;
    logic        o_memWe;
    logic        i_memAck;
    logic        i_trapClear;
    logic        o_irWe;
    logic        o_pcWe;
    logic        o_regWe;
    logic        o_trap;
    logic [1:0]  o_trapCause;
    logic [2:0]  o_state;

    // Sequencer side.
    modport master (
        input  i_instr, i_fetchAck, i_memAck, i_trapClear,
        output o_fetchReq, o_memReq, o_memWe, o_irWe, o_pcWe, o_regWe,
               o_trap, o_trapCause, o_state
    );

    // Memory / trap-handler side.
    modport slave (
        output i_instr, i_fetchAck, i_memAck, i_trapClear,
        input  o_fetchReq, o_memReq, o_memWe, o_irWe, o_pcWe, o_regWe,
               o_trap, o_trapCause, o_state
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the non-pipelined core.
// Decides when IR, PC and register-file writes happen and parks in TRAP on
// ECALL, EBREAK, illegal opcode or a data-memory timeout.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst_n,
    instr_sequencer_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Coarse classes: only what changes the stage sequence matters here.
    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,  // R, I_ARITH, I_JUMP, LUI, AUIPC, J: go through WB
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_FLOW  = 3'd3,  // B and FENCE: PC commit in EXEC, no WB
        CLS_SYS   = 3'd4,
        CLS_ILL   = 3'd5
    } cls_t;

    state_t         state, state_d;
    cls_t           cls_q, cls_in;
    logic           ebreak_q, ebreak_in;
    logic [1:0]     cause_q, cause_d;
    logic [CW-1:0]  wait_cnt;

    logic fetch_req, mem_req, mem_we, ir_we, pc_we, reg_we, trap;

    // Opcode class of the word on the instruction bus.
    always_comb begin
        cls_in    = CLS_ILL;
        ebreak_in = (bus.i_instr[31:20] == 12'h001);
        case (bus.i_instr[6:0])
            7'b0110011, 7'b1100111, 7'b0010011,
            7'b0110111, 7'b0010111, 7'b1101111: cls_in = CLS_ALU;
            7'b0000011:                         cls_in = CLS_LOAD;
            7'b0100011:                         cls_in = CLS_STORE;
            7'b1100011, 7'b0001111:             cls_in = CLS_FLOW;
            7'b1110011:                         cls_in = CLS_SYS;
            default:                            cls_in = CLS_ILL;
        endcase
    end

    // State, captured class and trap cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            cls_q    <= CLS_ALU;
            ebreak_q <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            if (state == ST_FETCH && bus.i_fetchAck) begin
                cls_q    <= cls_in;
                ebreak_q <= ebreak_in;
            end
        end
    end

    // Data-memory wait counter: zero outside MEM, counts cycles spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ST_MEM && state_d == ST_MEM)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Next state and per-stage control pulses.
    always_comb begin
        state_d   = state;
        cause_d   = cause_q;
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        trap      = 1'b0;
        case (state)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (bus.i_fetchAck) begin
                    ir_we   = rst_n;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls_q == CLS_ILL) begin
                    cause_d = 2'd2;
                    state_d = ST_TRAP;
                end else if (cls_q == CLS_SYS) begin
                    cause_d = ebreak_q ? 2'd1 : 2'd0;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_FLOW) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                // An ack in the last allowed cycle still completes the access.
                if (bus.i_memAck) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    cause_d = 2'd3;
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
                // The trap handler reloads PC itself, so no pc_we on exit.
                if (bus.i_trapClear)
                    state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.o_fetchReq  = fetch_req;
    assign bus.o_memReq    = mem_req;
    assign bus.o_memWe     = mem_we;
    assign bus.o_irWe      = ir_we;
    assign bus.o_pcWe      = pc_we;
    assign bus.o_regWe     = reg_we;
    assign bus.o_trap      = trap;
    assign bus.o_trapCause = cause_q;
    assign bus.o_state     = state;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, a reset-during-MEM
// sequence and randomized instruction streams checked cycle by cycle against
// a per-instruction trace model.
module tb_instr_sequencer;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected per-cycle output word and the inputs driven in that cycle.
    logic [11:0] exp_q[$];
    logic [2:0]  drv_q[$];
    logic [31:0] ins_q[$];
    logic [1:0]  model_cause = 2'd0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          fetch_wait;
        int          ack_at;      // MEM cycle index of the ack, -1 = never
        int          clear_wait;
        int          exp_turn;    // cycles from fetch-ack to next fetch request
        bit          exp_trap;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[12];

    // {state, fetchReq, memReq, memWe, irWe, pcWe, regWe, trap, trapCause}
    function automatic logic [11:0] dut_vec();
        return {bus.o_state, bus.o_fetchReq, bus.o_memReq, bus.o_memWe, bus.o_irWe,
                bus.o_pcWe, bus.o_regWe, bus.o_trap, bus.o_trapCause};
    endfunction

    function automatic logic [11:0] ev(input logic [2:0] st, input logic ir,
                                       input logic pc, input logic rg, input logic mw);
        return {st, st == 3'd0, st == 3'd3, mw, ir, pc, rg, st == 3'd5, model_cause};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // 0 alu, 1 load, 2 store, 3 branch/fence, 4 system, 5 illegal
    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b1100111, 7'b0010011,
            7'b0110111, 7'b0010111, 7'b1101111: return 0;
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b1100011, 7'b0001111: return 3;
            7'b1110011: return 4;
            default:    return 5;
        endcase
    endfunction

    task automatic push(input logic [11:0] e, input logic fa, input logic ma,
                        input logic tc, input logic [31:0] ins);
        exp_q.push_back(e);
        drv_q.push_back({fa, ma, tc});
        ins_q.push_back(ins);
    endtask

    task automatic trap_tail(input int cw);
        for (int i = 0; i < cw; i++) push(ev(3'd5, 0, 0, 0, 0), rb(), rb(), 1'b0, $urandom);
        push(ev(3'd5, 0, 0, 0, 0), rb(), rb(), 1'b1, $urandom);
    endtask

    // Expected cycle trace of one instruction, starting in FETCH and ending
    // with the last cycle before the sequencer is back in FETCH.
    task automatic build(input logic [31:0] instr, input int fw, input int ack_at, input int cw);
        int  k;
        int  n;
        logic st;
        k  = kind_of(instr[6:0]);
        st = (k == 2);
        for (int i = 0; i < fw; i++) push(ev(3'd0, 0, 0, 0, 0), 1'b0, rb(), rb(), $urandom);
        push(ev(3'd0, 1, 0, 0, 0), 1'b1, rb(), rb(), instr);
        push(ev(3'd1, 0, 0, 0, 0), rb(), rb(), rb(), $urandom);
        if (k == 5 || k == 4) begin
            model_cause = (k == 5) ? 2'd2 : ((instr[31:20] == 12'h001) ? 2'd1 : 2'd0);
            trap_tail(cw);
            return;
        end
        push(ev(3'd2, 0, k == 3, 0, 0), rb(), rb(), rb(), $urandom);
        if (k == 0) push(ev(3'd4, 0, 1, 1, 0), rb(), rb(), rb(), $urandom);
        if (k == 1 || k == 2) begin
            n = (ack_at < 0) ? T : ack_at;
            for (int i = 0; i < n; i++) push(ev(3'd3, 0, 0, 0, st), rb(), 1'b0, rb(), $urandom);
            if (ack_at >= 0) begin
                push(ev(3'd3, 0, st, 0, st), rb(), 1'b1, rb(), $urandom);
                if (k == 1) push(ev(3'd4, 0, 1, 1, 0), rb(), rb(), rb(), $urandom);
            end else begin
                model_cause = 2'd3;
                trap_tail(cw);
            end
        end
    endtask

    // Drive the queued trace and compare every cycle; reports where the DUT
    // raised irWe and the first fetch request after it.
    task automatic apply(input string tag, output int ack_idx, output int req_idx);
        ack_idx = -1;
        req_idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            {bus.i_fetchAck, bus.i_memAck, bus.i_trapClear} = drv_q[i];
            bus.i_instr = ins_q[i];
            #1;
            chk($sformatf("%s cyc%0d", tag, i), int'(dut_vec()), int'(exp_q[i]));
            if (bus.o_irWe && ack_idx < 0) ack_idx = i;
            else if (ack_idx >= 0 && bus.o_fetchReq && req_idx < 0) req_idx = i;
        end
        exp_q.delete();
        drv_q.delete();
        ins_q.delete();
    endtask

    task automatic sample_after_negedge(input logic fa, input logic ma, input logic tc);
        @(negedge clk);
        {bus.i_fetchAck, bus.i_memAck, bus.i_trapClear} = {fa, ma, tc};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r, n;
        vec_t v;
        logic [6:0] ops[14];

        //          name       instr         fw ack cw turn trap cause
        vecs[0]  = '{"r_type",   32'h00000033, 2, -1, 0, 4, 0, 2'd0};
        vecs[1]  = '{"load3",    32'h00002003, 0,  2, 0, 7, 0, 2'd0};
        vecs[2]  = '{"store4",   32'h00002023, 0,  3, 0, 7, 0, 2'd0};
        vecs[3]  = '{"store_to", 32'h00002023, 0, -1, 1, 9, 1, 2'd3};
        vecs[4]  = '{"ecall",    32'h00000073, 1, -1, 2, 5, 1, 2'd0};
        vecs[5]  = '{"ebreak",   32'h00100073, 0, -1, 0, 3, 1, 2'd1};
        vecs[6]  = '{"illegal",  32'h0000007F, 0, -1, 1, 4, 1, 2'd2};
        vecs[7]  = '{"branch",   32'h00000063, 0, -1, 0, 3, 0, 2'd0};
        vecs[8]  = '{"fence",    32'h0000000F, 1, -1, 0, 3, 0, 2'd0};
        vecs[9]  = '{"lui",      32'h00000037, 0, -1, 0, 4, 0, 2'd0};
        vecs[10] = '{"jal",      32'h0000006F, 0, -1, 0, 4, 0, 2'd0};
        vecs[11] = '{"load1",    32'h00002003, 0,  0, 0, 5, 0, 2'd0};

        // Reset: outputs at their reset values even with a fetch ack present.
        rst_n = 1'b0;
        bus.i_instr = 32'h00000033;
        bus.i_fetchAck = 1'b1;
        bus.i_memAck = 1'b1;
        bus.i_trapClear = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_outputs", int'(dut_vec()), int'(ev(3'd0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        {bus.i_fetchAck, bus.i_memAck, bus.i_trapClear} = 3'b000;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            build(v.instr, v.fetch_wait, v.ack_at, v.clear_wait);
            n = exp_q.size();
            apply(v.name, a, r);
            sample_after_negedge(1'b0, 1'b0, 1'b0);
            chk({v.name, " idle"}, int'({bus.o_state, bus.o_fetchReq, bus.o_pcWe}), int'({3'd0, 1'b1, 1'b0}));
            if (r < 0 && bus.o_fetchReq) r = n;
            chk({v.name, " turnaround"}, r - a, v.exp_turn);
            if (v.exp_trap) chk({v.name, " cause"}, int'(bus.o_trapCause), int'(v.exp_cause));
        end

        // Reset pulsed during a MEM wait.
        sample_after_negedge(1'b1, 1'b0, 1'b0);
        bus.i_instr = 32'h00002003;
        #0;
        chk("rst_mem ack irWe", int'(bus.o_irWe), 1);
        sample_after_negedge(1'b0, 1'b0, 1'b0);
        sample_after_negedge(1'b0, 1'b0, 1'b0);
        sample_after_negedge(1'b0, 1'b0, 1'b0);
        chk("rst_mem in MEM", int'({bus.o_state, bus.o_memReq}), int'({3'd3, 1'b1}));
        sample_after_negedge(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_cause = 2'd0;
        #1;
        chk("rst_mem async", int'(dut_vec()), int'(ev(3'd0, 0, 0, 0, 0)));
        for (int i = 0; i < 2; i++) begin
            sample_after_negedge(1'b0, 1'b1, 1'b0);
            chk($sformatf("rst_mem hold%0d", i), int'(dut_vec()), int'(ev(3'd0, 0, 0, 0, 0)));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_after_negedge(1'b0, 1'b1, 1'b1);
            chk($sformatf("rst_mem stray%0d", i), int'(dut_vec()), int'(ev(3'd0, 0, 0, 0, 0)));
        end

        // Randomized instruction stream.
        ops = '{7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011,
                7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b1111111, 7'b0000000, 7'b1011011};
        for (int i = 0; i < 150; i++) begin
            logic [31:0] rw;
            logic [31:0] ins;
            int ack_at;
            rw  = $urandom;
            ins = {rw[31:7], ops[$urandom_range(0, 13)]};
            if (ins[6:0] == 7'b1110011 && rb()) ins[31:20] = 12'h001;
            ack_at = $urandom_range(0, T);
            if (ack_at == T) ack_at = -1;
            build(ins, $urandom_range(0, 2), ack_at, $urandom_range(0, 2));
            apply($sformatf("rand%0d op%02h", i, ins[6:0]), a, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the non-pipelined flintRV build variant. It handshakes with instruction and data memory and decodes the opcode class of the fetched word. It steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB, issuing IR, PC and register-file write enables, and parks in a TRAP state on ECALL, EBREAK, illegal opcode or data-bus timeout. It sits beside ControlUnit: ControlUnit supplies datapath mux controls and this block supplies *when* each stage's writes happen.

## Interface
- MEM_TIMEOUT, 16: data-memory wait limit in cycles (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_instr  in  32  instruction word, valid when i_fetchAck=1
- o_fetchReq  out  1  instruction fetch request
- i_fetchAck  in  1  instruction valid / fetch done
- o_memReq  out  1  data access request
- o_memWe  out  1  data access is a store
- i_memAck  in  1  data access done
- i_trapClear  in  1  trap handled, resume fetch
- o_irWe  out  1  capture i_instr into IR
- o_pcWe  out  1  commit next PC
- o_regWe  out  1  register-file write
- o_trap  out  1  sequencer halted in TRAP
- o_trapCause  out  2  0=ECALL, 1=EBREAK, 2=illegal, 3=bus timeout
- o_state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5

## Operation
- Opcode classes (i_instr[6:0]):
  - R 0110011, I_JUMP 1100111, I_LOAD 0000011, I_ARITH 0010011
  - I_SYS 1110011, I_FENCE 0001111, S 0100011, B 1100011
  - U_LUI 0110111, U_AUIPC 0010111, J 1101111
  - Anything else is illegal.
- Captured at fetch-accept: class, plus the I_SYS qualifier (i_instr[31:20]==12'h001 → EBREAK, else ECALL).
- FETCH:
  - o_fetchReq=1.
  - On i_fetchAck: o_irWe=1 (combinational, same cycle), capture class, → DECODE.
  - No timeout.
- DECODE: illegal → TRAP cause 2; I_SYS → TRAP cause 1 or 0; else → EXEC.
- EXEC:
  - I_LOAD/S → MEM.
  - B/I_FENCE → FETCH with o_pcWe=1 this cycle.
  - Others → WB.
- MEM:
  - o_memReq=1; o_memWe=1 for S.
  - Wait counter cleared on entry, increments each MEM cycle without ack.
  - On i_memAck: load → WB; store → FETCH with o_pcWe=1 this cycle.
  - No ack in MEM_TIMEOUT consecutive cycles → TRAP cause 3.
  - Ack in the final allowed cycle wins over timeout.
- WB: o_regWe=1, o_pcWe=1 for one cycle, → FETCH.
- TRAP:
  - o_trap=1 and o_trapCause held.
  - On i_trapClear → FETCH; no pcWe (trap logic loads PC externally).
- Acks and i_trapClear outside their own states are ignored.
- Counter width is clog2(MEM_TIMEOUT+1).

## Timing
- State register updates on rising clk; rst_n low forces FETCH immediately, regardless of clock.
- Reset values:
  - o_state=0, o_fetchReq=1.
  - o_memReq, o_memWe, o_irWe, o_pcWe, o_regWe, o_trap = 0; o_trapCause=0.
  - Wait counter 0.
- Outputs are decoded from the state register (Moore), except o_irWe and the EXEC/MEM o_pcWe, which also depend on the same-cycle ack or class (Mealy).
- Cycle counts, measured from the fetch-ack cycle to the next o_fetchReq:
  - R/I_ARITH/LUI/AUIPC/J/I_JUMP: 4 cycles.
  - B/FENCE: 3 cycles.
  - Load with ack on the first MEM cycle: 5 cycles; each wait cycle adds 1.
  - Store with ack on the first MEM cycle: 4 cycles.
- Trap entry happens one cycle after fetch-ack for decode traps.
- Each control pulse is exactly one cycle wide per instruction.
- Reset asserted mid-MEM drops o_memReq immediately; no o_regWe or o_pcWe is issued for the interrupted instruction.

## Test plan
- R-type 0x00000033, ack after 2 wait cycles:
  - FETCH→DECODE→EXEC→WB→FETCH.
  - One o_irWe pulse; o_regWe and o_pcWe together in WB.
  - Next o_fetchReq 4 cycles after ack.
- Load 0x00002003, i_memAck on 3rd MEM cycle:
  - o_memReq high 3 cycles, o_memWe=0.
  - WB follows, then FETCH.
- Store 0x00002023 with MEM_TIMEOUT=4:
  - Ack in 4th MEM cycle → FETCH with o_pcWe, o_memWe=1 throughout.
  - Repeat with no ack → TRAP cause 3 after exactly 4 MEM cycles.
- System and illegal opcodes:
  - 0x00000073 → TRAP cause 0.
  - 0x00100073 → TRAP cause 1.
  - 0x0000007F → TRAP cause 2.
  - Each holds TRAP until i_trapClear, then FETCH with o_pcWe=0.
- Branch 0x00000063 and fence 0x0000000F: o_pcWe in EXEC, o_regWe never asserted, 3-cycle turnaround.
- rst_n pulsed low during MEM wait:
  - o_state=0 and o_memReq=0 asynchronously.
  - No o_regWe/o_pcWe; o_fetchReq=1 after release.
  - Stray i_memAck and i_trapClear during FETCH have no effect.
